// File: rtl/led_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, bounce direction and mode stepping.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL,
    MODE_CHASE,
    MODE_BOUNCE
  } mode_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // Modes advance in a fixed ring, one step per key press.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      MODE_OFF:   r = MODE_ALL;
      MODE_ALL:   r = MODE_CHASE;
      MODE_CHASE: r = MODE_BOUNCE;
      default:    r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Board-side bundle for led_pattern_seq: active-low keys in; LED drive, current mode and tick pulse out.
interface led_pattern_seq_if
  import led_pkg::*;
#(
  parameter int unsigned NLED = 8
) ();

  logic              KEY_SPEED;
  logic              KEY_MODE;
  logic [NLED-1:0]   LEDG;
  logic [MODE_W-1:0] MODE;
  logic              TICK;

  modport master (output KEY_SPEED, KEY_MODE, input LEDG, MODE, TICK);
  modport slave  (input KEY_SPEED, KEY_MODE, output LEDG, MODE, TICK);

endinterface

// File: rtl/led_tick_gen.sv
// Shared prescaler: one-cycle tick each time cnt passes TICK_DIV, stepping by FAST_STEP while fast is set.
// tick registered (period TICK_DIV/step + 1 cycles); clear restarts the count and drops a pending tick; no backpressure.
module led_tick_gen #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned FAST_STEP = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fast,
  input  logic clear,
  output logic tick
);

  // Wide enough for the largest pre-wrap value plus one fast step.
  localparam int CNT_W = $clog2(TICK_DIV + FAST_STEP + 1);
  localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] FAST_C = CNT_W'(FAST_STEP);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= DIV_C) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + (fast ? FAST_C : ONE_C);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// Steps NLED LEDs through OFF/ALL/CHASE/BOUNCE on a shared tick; KEY_MODE press lands 3 cycles after the pin edge (3+DB_CYCLES when DEBOUNCE_EN is defined).
// LEDG updates the cycle after TICK; a press in that same cycle wins and discards the tick; no backpressure.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned FAST_STEP = 5,
  parameter int unsigned NLED      = 8
`ifdef DEBOUNCE_EN
  ,
  parameter int unsigned DB_CYCLES = 1000000
`endif
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  led_pattern_seq_if.slave bus
);

  localparam int POS_W = $clog2(NLED);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NLED - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic mode_s1, mode_s2, spd_s1, spd_s2;
  logic key_lvl, key_prev, press, tick;

  // Synchronizers idle high so a held key at reset release is not a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_s1 <= 1'b1;
      mode_s2 <= 1'b1;
      spd_s1  <= 1'b1;
      spd_s2  <= 1'b1;
    end else begin
      mode_s1 <= bus.KEY_MODE;
      mode_s2 <= mode_s1;
      spd_s1  <= bus.KEY_SPEED;
      spd_s2  <= spd_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;

  // Filtered level follows only after DB_CYCLES consecutive cycles at the new level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_lvl <= 1'b1;
      db_cnt  <= '0;
    end else if (mode_s2 == key_lvl) begin
      db_cnt  <= '0;
    end else if (db_cnt == DB_LAST) begin
      key_lvl <= mode_s2;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + DB_W'(1);
    end
  end
`else
  assign key_lvl = mode_s2;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) key_prev <= 1'b1;
    else          key_prev <= key_lvl;
  end

  assign press = key_prev & ~key_lvl;

  led_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .FAST_STEP (FAST_STEP)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .fast  (~spd_s2),
    .clear (press),
    .tick  (tick)
  );

  mode_t            mode_q, mode_d;
  dir_t             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [NLED-1:0]  led_q, led_d;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= MODE_OFF;
      dir_q  <= DIR_UP;
      pos_q  <= '0;
      led_q  <= '0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pos_d  = pos_q;
    led_d  = led_q;
    if (press) begin
      mode_d = next_mode(mode_q);
      dir_d  = DIR_UP;
      pos_d  = '0;
      led_d  = '0;
      if (mode_d == MODE_CHASE || mode_d == MODE_BOUNCE) led_d[0] = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_ALL:   led_d = ~led_q;
        MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        MODE_BOUNCE: begin
          // Turn around at an end so the end LED is lit for exactly one tick.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              dir_d = DIR_DOWN;
              pos_d = pos_q - POS_ONE;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_ONE;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: led_d = '0;
      endcase
      if (mode_q == MODE_CHASE || mode_q == MODE_BOUNCE) begin
        led_d        = '0;
        led_d[pos_d] = 1'b1;
      end
    end
  end

  assign bus.LEDG = led_q;
  assign bus.MODE = mode_q;
  assign bus.TICK = tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with TICK_DIV=10, FAST_STEP=5, NLED=4 (DB_CYCLES=8 when DEBOUNCE_EN).
module tb_led_pattern_seq;

`ifdef DEBOUNCE_EN
  localparam int KL = 3 + 8;
`else
  localparam int KL = 3;
`endif

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   gap;

  led_pattern_seq_if #(.NLED(4)) bus ();

  led_pattern_seq #(
    .TICK_DIV  (10),
    .FAST_STEP (5),
    .NLED      (4)
`ifdef DEBOUNCE_EN
    ,
    .DB_CYCLES (8)
`endif
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Returns the number of falling edges until TICK is seen high.
  task automatic wait_tick(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge CLOCK_50);
      if (bus.TICK) n = i;
    end
    if (n == 0) check({tag, "_timeout"}, 32'(bus.TICK), 32'd1);
  endtask

  task automatic step_tick(input string tag, input logic [3:0] want);
    int n;
    wait_tick(tag, n);
    @(negedge CLOCK_50);
    check(tag, 32'(bus.LEDG), 32'(want));
  endtask

  task automatic press_mode(input string tag, input int old_mode, input int new_mode);
    bus.KEY_MODE = 1'b0;
    repeat (KL - 1) @(negedge CLOCK_50);
    check({tag, "_early"}, 32'(bus.MODE), old_mode);
    @(negedge CLOCK_50);
    check(tag, 32'(bus.MODE), new_mode);
    bus.KEY_MODE = 1'b1;
  endtask

  initial begin
    bus.KEY_MODE  = 1'b1;
    bus.KEY_SPEED = 1'b1;
    #23;
    check("rst_mode", 32'(bus.MODE), 32'd0);
    check("rst_led",  32'(bus.LEDG), 32'd0);
    check("rst_tick", 32'(bus.TICK), 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Idle OFF: tick every 11 cycles, LEDs dark
    wait_tick("off_first", gap);
    check("off_first_gap", gap, 32'd11);
    wait_tick("off_gap", gap);
    check("off_gap", gap, 32'd11);
    check("off_led", 32'(bus.LEDG), 32'd0);

    // ALL: first tick 11 cycles after the press, then invert per tick
    press_mode("to_all", 0, 1);
    check("all_init", 32'(bus.LEDG), 32'd0);
    wait_tick("all_t1", gap);
    check("all_t1_gap", gap, 32'd11);
    check("all_t1_pre", 32'(bus.LEDG), 32'h0);
    @(negedge CLOCK_50);
    check("all_t1", 32'(bus.LEDG), 32'hF);
    step_tick("all_t2", 4'b0000);

    // Fast speed: interval 3, then back to 11
    bus.KEY_SPEED = 1'b0;
    wait_tick("fast_align", gap);
    wait_tick("fast_gap1", gap);
    check("fast_gap1", gap, 32'd3);
    wait_tick("fast_gap2", gap);
    check("fast_gap2", gap, 32'd3);
    bus.KEY_SPEED = 1'b1;
    wait_tick("slow_align", gap);
    wait_tick("slow_gap", gap);
    check("slow_gap", gap, 32'd11);

    // CHASE
    press_mode("to_chase", 1, 2);
    check("chase_init", 32'(bus.LEDG), 32'h1);
    step_tick("chase_1", 4'b0010);
    step_tick("chase_2", 4'b0100);
    step_tick("chase_3", 4'b1000);
    step_tick("chase_4", 4'b0001);

    // Press lands on the cycle TICK is high: press wins
    repeat (11 - KL) @(negedge CLOCK_50);
    press_mode("to_bounce", 2, 3);
    check("bounce_init", 32'(bus.LEDG), 32'h1);
    wait_tick("bounce_t1", gap);
    check("bounce_t1_gap", gap, 32'd11);
    @(negedge CLOCK_50);
    check("bounce_1", 32'(bus.LEDG), 32'h2);
    step_tick("bounce_2", 4'b0100);
    step_tick("bounce_3", 4'b1000);
    step_tick("bounce_4", 4'b0100);
    step_tick("bounce_5", 4'b0010);
    step_tick("bounce_6", 4'b0001);
    step_tick("bounce_7", 4'b0010);

    // Asynchronous reset mid-pattern
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    check("arst_mode", 32'(bus.MODE), 32'd0);
    check("arst_led",  32'(bus.LEDG), 32'd0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Short glitch, then a long hold and release
    bus.KEY_MODE = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    bus.KEY_MODE = 1'b1;
    repeat (5) @(negedge CLOCK_50);
`ifdef DEBOUNCE_EN
    check("glitch", 32'(bus.MODE), 32'd0);
`else
    check("glitch", 32'(bus.MODE), 32'd1);
`endif
    bus.KEY_MODE = 1'b0;
    repeat (12) @(negedge CLOCK_50);
`ifdef DEBOUNCE_EN
    check("hold", 32'(bus.MODE), 32'd1);
`else
    check("hold", 32'(bus.MODE), 32'd2);
`endif
    bus.KEY_MODE = 1'b1;
    repeat (20) @(negedge CLOCK_50);
`ifdef DEBOUNCE_EN
    check("release", 32'(bus.MODE), 32'd1);
`else
    check("release", 32'(bus.MODE), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
